// File: rtl/ledstrip_pkg.sv
// Shared definitions for the LED strip frame sender: FSM states and default
// WS2812 timing at a 50 MHz clock (20 ns per cycle).
package ledstrip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BIT   = 2'd2,
    ST_LATCH = 2'd3
  } led_state_e;

  localparam int COLOR_W       = 24;
  localparam int DEF_T0H_CYC   = 20;    // 400 ns high for a 0 bit
  localparam int DEF_T1H_CYC   = 40;    // 800 ns high for a 1 bit
  localparam int DEF_BIT_CYC   = 63;    // 1.26 us bit period
  localparam int DEF_RESET_CYC = 2600;  // 52 us low latch

  // Width of a counter or index covering 0..n-1, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter for the WS2812 waveform. Produces the bit_end strobe on
// the last cycle of a bit and the high/low decision for the following cycle so
// the parent can register dout in step with its state.
module ws2812_bit_timer
  import ledstrip_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic run,        // currently in a bit period
  input  logic run_next,   // next cycle is in a bit period
  input  logic bit_next,   // data bit being sent next cycle
  output logic bit_end,    // last cycle of the current bit
  output logic high_next   // dout level for next cycle
);

  localparam int CNT_W = idx_width(BIT_CYC);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] T0H_C  = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_C  = CNT_W'(T1H_CYC);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             bit_end_s;

  // Next count: advance inside a bit, restart at 0 on bit end or when idle.
  always_comb begin
    cnt_next_s = '0;
    bit_end_s  = run && (cnt_r == LAST_C);
    if (run && !bit_end_s) begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_next_s = '0;
    end
    high_next = run_next && (cnt_next_s < (bit_next ? T1H_C : T0H_C));
  end

  assign bit_end = bit_end_s;

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: rtl/led_frame_sender.sv
// WS2812 frame sender: on refresh, fetches NUM_LEDS colours by index and
// shifts them out MSB first, then holds the line low for the latch time.
// Refresh requests arriving mid-frame coalesce into one follow-on frame.
module led_frame_sender
  import ledstrip_pkg::*;
#(
  parameter int NUM_LEDS  = 100,
  parameter int T0H_CYC   = DEF_T0H_CYC,
  parameter int T1H_CYC   = DEF_T1H_CYC,
  parameter int BIT_CYC   = DEF_BIT_CYC,
  parameter int RESET_CYC = DEF_RESET_CYC
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             refresh,
  output logic [idx_width(NUM_LEDS)-1:0]   led_index,
  input  logic [COLOR_W-1:0]               led_color,
  output logic                             dout,
  output logic                             busy,
  output logic                             frame_done
);

  localparam int IDX_W = idx_width(NUM_LEDS);
  localparam int LAT_W = idx_width(RESET_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEDS - 1);
  localparam logic [LAT_W-1:0] LATCH_LAST = LAT_W'(RESET_CYC - 1);

  if (!((T0H_CYC < T1H_CYC) && (T1H_CYC < BIT_CYC))) begin : g_bad_timing
    $error("led_frame_sender: timing must satisfy T0H_CYC < T1H_CYC < BIT_CYC");
  end
  if ((NUM_LEDS < 1) || (RESET_CYC < 1)) begin : g_bad_size
    $error("led_frame_sender: NUM_LEDS and RESET_CYC must be at least 1");
  end

  led_state_e         state_r, state_next_s;
  logic [IDX_W-1:0]   led_index_r;
  logic [COLOR_W-1:0] shift_r;
  logic [4:0]         bit_cnt_r;
  logic [LAT_W-1:0]   latch_cnt_r;
  logic               pending_r, dout_r, busy_r, frame_done_r;

  logic bit_end_s, high_next_s, bit_next_s, latch_end_s;
  logic shift_s, idx_inc_s, idx_clr_s;

  ws2812_bit_timer #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (state_r == ST_BIT),
    .run_next  (state_next_s == ST_BIT),
    .bit_next  (bit_next_s),
    .bit_end   (bit_end_s),
    .high_next (high_next_s)
  );

  // Next-state logic plus datapath control strobes.
  always_comb begin
    state_next_s = state_r;
    bit_next_s   = shift_r[COLOR_W-1];
    shift_s      = 1'b0;
    idx_inc_s    = 1'b0;
    idx_clr_s    = 1'b0;
    latch_end_s  = (state_r == ST_LATCH) && (latch_cnt_r == LATCH_LAST);
    case (state_r)
      ST_IDLE: begin
        if (refresh) begin
          state_next_s = ST_LOAD;
          idx_clr_s    = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_next_s = ST_BIT;
        bit_next_s   = led_color[COLOR_W-1];
      end
      ST_BIT: begin
        if (!bit_end_s) begin
          state_next_s = ST_BIT;
        end else if (bit_cnt_r != 5'd0) begin
          state_next_s = ST_BIT;
          shift_s      = 1'b1;
          bit_next_s   = shift_r[COLOR_W-2];
        end else if (led_index_r < LAST_IDX) begin
          state_next_s = ST_LOAD;
          idx_inc_s    = 1'b1;
        end else begin
          state_next_s = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (latch_end_s) begin
          idx_clr_s    = 1'b1;
          state_next_s = (pending_r || refresh) ? ST_LOAD : ST_IDLE;
        end else begin
          state_next_s = ST_LATCH;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      led_index_r  <= '0;
      shift_r      <= '0;
      bit_cnt_r    <= 5'd0;
      latch_cnt_r  <= '0;
      pending_r    <= 1'b0;
      dout_r       <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r <= state_next_s;

      if (idx_clr_s) begin
        led_index_r <= '0;
      end else if (idx_inc_s) begin
        led_index_r <= led_index_r + IDX_W'(1);
      end else begin
        led_index_r <= led_index_r;
      end

      if (state_r == ST_LOAD) begin
        shift_r   <= led_color;
        bit_cnt_r <= 5'd23;
      end else if (shift_s) begin
        shift_r   <= {shift_r[COLOR_W-2:0], 1'b0};
        bit_cnt_r <= bit_cnt_r - 5'd1;
      end else begin
        shift_r   <= shift_r;
        bit_cnt_r <= bit_cnt_r;
      end

      if ((state_r == ST_LATCH) && !latch_end_s) begin
        latch_cnt_r <= latch_cnt_r + LAT_W'(1);
      end else begin
        latch_cnt_r <= '0;
      end

      // A request at the latch exit is consumed by the restart itself.
      if (latch_end_s) begin
        pending_r <= 1'b0;
      end else if (refresh && (state_r != ST_IDLE)) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end

      dout_r       <= high_next_s;
      busy_r       <= (state_next_s != ST_IDLE);
      frame_done_r <= latch_end_s;
    end
  end

  assign led_index  = led_index_r;
  assign dout       = dout_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_led_frame_sender.sv
// Directed bench for led_frame_sender with small timing (T0H=2, T1H=4, BIT=6,
// RESET=10). A two-LED instance and a one-LED instance share clock and stimulus.
module tb_led_frame_sender;

  logic        clk = 1'b0;
  logic        reset, refresh;
  logic [0:0]  idx_a, idx_b;
  logic [23:0] color_a, color_b;
  logic        dout_a, busy_a, fd_a;
  logic        dout_b, busy_b, fd_b;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int   cyc;
    logic busy;
    logic fd;
    int   idx;
    logic dout;
  } vec_t;

  vec_t tab [15];

  always #5 clk = ~clk;

  function automatic logic [23:0] col_of(input int i);
    return (i == 0) ? 24'h800000 : 24'hFF00A5;
  endfunction

  // Combinational colour lookup, as a frame buffer would provide.
  always_comb color_a = col_of(int'(idx_a));
  always_comb color_b = col_of(int'(idx_b));

  led_frame_sender #(.NUM_LEDS(2), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RESET_CYC(10)) dut_a (
    .clk(clk), .reset(reset), .refresh(refresh), .led_index(idx_a),
    .led_color(color_a), .dout(dout_a), .busy(busy_a), .frame_done(fd_a));

  led_frame_sender #(.NUM_LEDS(1), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RESET_CYC(10)) dut_b (
    .clk(clk), .reset(reset), .refresh(refresh), .led_index(idx_b),
    .led_color(color_b), .dout(dout_b), .busy(busy_b), .frame_done(fd_b));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Expected dout for a frame whose LOAD cycle is s: bits of LED0 in s+1..s+144,
  // LOAD of LED1 at s+145, bits of LED1 in s+146..s+289, low elsewhere.
  function automatic int model_dout(input int c, input int s, input int nl);
    int k, off, led, ph;
    logic [23:0] cv;
    k = c - s;
    if (k >= 1 && k <= 144) begin
      led = 0; off = k - 1;
    end else if (nl > 1 && k >= 146 && k <= 289) begin
      led = 1; off = k - 146;
    end else begin
      return 0;
    end
    cv = col_of(led);
    ph = off % 6;
    return (ph < (cv[23 - off / 6] ? 4 : 2)) ? 1 : 0;
  endfunction

  task automatic reset_dut();
    reset   = 1'b1;
    refresh = 1'b0;
    repeat (3) tick();
    chk("rst_dout", dout_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_fd",   fd_a,   0);
    chk("rst_idx",  int'(idx_a), 0);
    chk("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Two-frame run: refresh at 0 plus requests at ra/rb during the first frame.
  task automatic run_two(input string tag, input int ra, input int rb);
    reset_dut();
    for (int c = 0; c <= 610; c++) begin
      refresh = (c == 0 || c == ra || c == rb);
      chk({tag, "_busy"}, busy_a, (c >= 1 && c <= 600) ? 1 : 0);
      chk({tag, "_fd"},   fd_a,   (c == 301 || c == 601) ? 1 : 0);
      if (c == 301) chk({tag, "_idx301"}, int'(idx_a), 0);
      if (c >= 301 && c <= 600) chk({tag, "_dout"}, dout_a, model_dout(c, 301, 2));
      tick();
    end
    refresh = 1'b0;
  endtask

  initial begin
    tab[0]  = '{0,   1'b0, 1'b0, 0, 1'b0};
    tab[1]  = '{1,   1'b1, 1'b0, 0, 1'b0};
    tab[2]  = '{2,   1'b1, 1'b0, 0, 1'b1};
    tab[3]  = '{5,   1'b1, 1'b0, 0, 1'b1};
    tab[4]  = '{6,   1'b1, 1'b0, 0, 1'b0};
    tab[5]  = '{8,   1'b1, 1'b0, 0, 1'b1};
    tab[6]  = '{10,  1'b1, 1'b0, 0, 1'b0};
    tab[7]  = '{145, 1'b1, 1'b0, 0, 1'b0};
    tab[8]  = '{146, 1'b1, 1'b0, 1, 1'b0};
    tab[9]  = '{147, 1'b1, 1'b0, 1, 1'b1};
    tab[10] = '{290, 1'b1, 1'b0, 1, 1'b0};
    tab[11] = '{291, 1'b1, 1'b0, 1, 1'b0};
    tab[12] = '{300, 1'b1, 1'b0, 1, 1'b0};
    tab[13] = '{301, 1'b0, 1'b1, 0, 1'b0};
    tab[14] = '{302, 1'b0, 1'b0, 0, 1'b0};

    // Single frame: table points plus cycle-by-cycle waveform on both instances.
    reset_dut();
    for (int c = 0; c <= 305; c++) begin
      refresh = (c == 0);
      for (int i = 0; i < 15; i++) begin
        if (tab[i].cyc == c) begin
          chk("s1_busy", busy_a, int'(tab[i].busy));
          chk("s1_fd",   fd_a,   int'(tab[i].fd));
          chk("s1_idx",  int'(idx_a), tab[i].idx);
          chk("s1_dout", dout_a, int'(tab[i].dout));
        end
      end
      chk("s1_dout_wave", dout_a, model_dout(c, 1, 2));
      chk("s1_fd_wave",   fd_a,   (c == 301) ? 1 : 0);
      chk("one_dout", dout_b, model_dout(c, 1, 1));
      chk("one_busy", busy_b, (c >= 1 && c <= 155) ? 1 : 0);
      chk("one_fd",   fd_b,   (c == 156) ? 1 : 0);
      chk("one_idx",  int'(idx_b), 0);
      tick();
    end

    // Coalesced mid-frame requests, then a request in the last latch cycle.
    run_two("coal", 50, 200);
    run_two("last", 300, 300);

    // Reset mid-frame with a pending request and refresh held during reset.
    reset_dut();
    for (int c = 0; c <= 400; c++) begin
      refresh = (c == 0 || c == 50 || c == 100);
      reset   = (c == 100);
      if (c == 101) begin
        chk("abort_dout", dout_a, 0);
        chk("abort_idx",  int'(idx_a), 0);
      end
      chk("abort_busy", busy_a, (c >= 1 && c <= 100) ? 1 : 0);
      chk("abort_fd",   fd_a, 0);
      tick();
    end
    reset   = 1'b0;
    refresh = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_frame_sender.md
LED_FRAME_SENDER -- requirements
Module: led_frame_sender

Interface
REQ-001 Parameter NUM_LEDS, 100, LEDs in strip chain (>=1).
REQ-002 Parameter T0H_CYC, 20, clk cycles dout high for a 0 bit.
REQ-003 Parameter T1H_CYC, 40, clk cycles dout high for a 1 bit.
REQ-004 Parameter BIT_CYC, 63, clk cycles per bit; T0H_CYC < T1H_CYC < BIT_CYC SHALL be enforced at elaboration.
REQ-005 Parameter RESET_CYC, 2600, clk cycles of dout low latch after the last bit.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 refresh  input  1  activity pulse from the activity detector; requests one full frame.
REQ-009 led_index  output  $clog2(NUM_LEDS) (min 1)  index of the LED whose colour is requested.
REQ-010 led_color  input  24  GRB colour for led_index; combinational lookup, sampled only in LOAD.
REQ-011 dout  output  1  WS2812 serial data line.
REQ-012 busy  output  1  high in LOAD, BIT and LATCH.
REQ-013 frame_done  output  1  one-cycle pulse after each completed frame.

Function
REQ-014 States SHALL be IDLE, LOAD, BIT, LATCH.
REQ-015 IDLE: dout=0, busy=0; refresh=1 -> LOAD next cycle, led_index=0.
REQ-016 LOAD: exactly 1 cycle, dout=0; shift register <= led_color, bit counter <= 23, cycle counter <= 0; -> BIT.
REQ-017 BIT: bits sent MSB first (G7 first, B0 last); dout=1 while cycle counter < (bit ? T1H_CYC : T0H_CYC), else 0.
REQ-018 BIT end (cycle counter = BIT_CYC-1): bit counter > 0 -> shift, decrement, stay in BIT; else led_index < NUM_LEDS-1 -> led_index+1, LOAD; else -> LATCH.
REQ-019 Per-LED duration SHALL be 1 + 24*BIT_CYC cycles; the LOAD cycle extends the preceding low time by one cycle.
REQ-020 LATCH: dout=0 for exactly RESET_CYC cycles, then frame_done=1 for one cycle coincident with leaving LATCH state.
REQ-021 refresh=1 in any non-IDLE state SHALL set a pending flag; multiple requests coalesce into one.
REQ-022 On LATCH exit with pending set (including refresh in the final LATCH cycle): clear pending, led_index=0, -> LOAD directly; frame_done still pulses.
REQ-023 refresh in the cycle frame_done is asserted (state IDLE) SHALL start a frame normally.
REQ-024 led_index SHALL never exceed NUM_LEDS-1; no wrap.
REQ-025 NUM_LEDS=1 SHALL go LOAD -> BIT -> LATCH without increment.
REQ-026 dout SHALL be registered (glitch-free).

Reset
REQ-027 reset=1 at any edge: state IDLE, dout=0, busy=0, frame_done=0, led_index=0, pending=0, counters=0.
REQ-028 Reset mid-frame SHALL abort without latch period; refresh during reset SHALL be ignored.

Structure
REQ-029 Shared package ledstrip_pkg SHALL hold the state enum and default timing constants (T0H/T1H/BIT/RESET at 50 MHz).
REQ-030 One sub-module ws2812_bit_timer (cycle counter, high-time compare, bit_end strobe); FSM and index logic stay in led_frame_sender.

Verification (NUM_LEDS=2, T0H=2, T1H=4, BIT=6, RESET=10)
REQ-031 refresh pulse cycle 0, led_color=0xFF0000 -> LOAD cycle 1; LED0 bits cycles 2..145, LOAD 146, LED1 147..290, LATCH 291..300, frame_done=1 cycle 301 only.
REQ-032 led_color=0x800000 -> first bit dout high 4 cycles/low 2, remaining 23 bits high 2/low 4.
REQ-033 refresh pulses at cycles 50 and 200 -> exactly one extra frame, LOAD at cycle 301 with frame_done=1, busy never drops.
REQ-034 refresh at cycle 300 (last LATCH cycle) -> back-to-back frame from cycle 301.
REQ-035 reset at cycle 100 mid-frame -> cycle 101: dout=0, busy=0, led_index=0; no frame_done; pending refresh discarded.
REQ-036 NUM_LEDS=1 -> LATCH starts cycle 146, frame_done at cycle 156, led_index stays 0.
